// File: rtl/cpu_host_driver_pkg.sv
// cpu_host_pkg: shared types and constants for the picoMIPS host driver.
//   host_state_t : driver FSM states, in phase order
//   HOST_SETTLE  : default cycles each switch phase is held
//   HOST_RUN     : default cycles the core is given to compute
//   HOST_READ    : cycles per display read window (covers the core's registered mux)
//   host_cnt_w() : phase counter width able to hold every phase length
package cpu_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_X,
    S_REL_X,
    S_LOAD_Y,
    S_REL_Y,
    S_RUN,
    S_READ_X,
    S_READ_Y,
    S_OUT
  } host_state_t;

  localparam int HOST_SETTLE = 4;
  localparam int HOST_RUN    = 32;
  localparam int HOST_READ   = 2;

  // The read window is also loaded into the counter, so it takes part in the
  // width; with SETTLE=RUN=1 a width of 1 would otherwise wrap the value 2.
  function automatic int host_cnt_w(input int settle, input int run);
    int m;
    m = settle;
    if (run > m) m = run;
    if (HOST_READ > m) m = HOST_READ;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cpu_host_driver_if.sv
// cpu_host_driver_if: host-side streams of the picoMIPS host driver.
//   in_valid/in_ready/in_x/in_y     : operand pair stream (host -> driver)
//   out_valid/out_ready/out_x/out_y : result pair stream (driver -> host)
//   master : host / test side
//   slave  : the driver
interface cpu_host_driver_if #(
  parameter int n = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_x;
  logic [n-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_x;
  logic [n-1:0] out_y;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_y
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_x, out_y
  );
endinterface

// File: rtl/cpu_host_driver_phase_timer.sv
// phase_timer: loadable down-counter timing one FSM phase.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   load     : load load_val (has priority over counting)
//   load_val : phase length in cycles
//   done     : high during the last cycle of the phase (count == 1)
// The count stops at 0 and never wraps.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/cpu_host_driver.sv
// cpu_host_driver: drives an (X1, Y1) pair into the picoMIPS core through its
// sws/sw8 switch handshake, waits RUN cycles, then reads x2 (sw8=0) and
// y2 (sw8=1) from the core's display and returns them as a result pair.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   host    : operand/result streams (slave modport)
//   sws     : registered switch value to the core
//   sw8     : registered handshake switch to the core
//   display : core display output
//   busy    : high in every state except idle
module cpu_host_driver
  import cpu_host_pkg::*;
#(
  parameter int n      = 8,
  parameter int SETTLE = HOST_SETTLE,
  parameter int RUN    = HOST_RUN
) (
  input  logic           clk,
  input  logic           reset,
  cpu_host_driver_if.slave host,
  output logic [n-1:0]   sws,
  output logic           sw8,
  input  logic [n-1:0]   display,
  output logic           busy
);

  localparam int CNT_W = host_cnt_w(SETTLE, RUN);

  host_state_t      state;
  logic [n-1:0]     x_q;
  logic [n-1:0]     y_q;
  logic             tmr_load;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_val;

  // Counter reload on every state change, with the length of the state being
  // entered. Idle and OUT are not timed, so they load 0.
  always_comb begin
    tmr_load = tmr_done;
    tmr_val  = '0;
    case (state)
      S_IDLE: begin
        tmr_load = host.in_valid;
        tmr_val  = CNT_W'(SETTLE);
      end
      S_LOAD_X, S_REL_X, S_LOAD_Y: tmr_val = CNT_W'(SETTLE);
      S_REL_Y:                     tmr_val = CNT_W'(RUN);
      S_RUN, S_READ_X:             tmr_val = CNT_W'(HOST_READ);
      S_READ_Y:                    tmr_val = '0;
      S_OUT:                       tmr_load = host.out_ready;
      default:                     tmr_load = 1'b0;
    endcase
  end

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // sws/sw8 are assigned on the transition into each state so their
  // registered values always match the state being occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      sws            <= '0;
      sw8            <= 1'b0;
      host.out_valid <= 1'b0;
      host.out_x     <= '0;
      host.out_y     <= '0;
    end else begin
      case (state)
        S_IDLE: if (host.in_valid) begin
          x_q   <= host.in_x;
          y_q   <= host.in_y;
          sws   <= host.in_x;
          sw8   <= 1'b0;
          state <= S_LOAD_X;
        end
        S_LOAD_X: if (tmr_done) begin
          sws   <= x_q;
          sw8   <= 1'b1;
          state <= S_REL_X;
        end
        S_REL_X: if (tmr_done) begin
          sws   <= y_q;
          state <= S_LOAD_Y;
        end
        S_LOAD_Y: if (tmr_done) begin
          sw8   <= 1'b0;
          state <= S_REL_Y;
        end
        S_REL_Y: if (tmr_done) begin
          state <= S_RUN;
        end
        S_RUN: if (tmr_done) begin
          state <= S_READ_X;
        end
        // display is registered in the core, so it reflects sw8 only on the
        // second cycle of each window; capture on that window's last edge.
        S_READ_X: if (tmr_done) begin
          host.out_x <= display;
          sw8        <= 1'b1;
          state      <= S_READ_Y;
        end
        S_READ_Y: if (tmr_done) begin
          host.out_y     <= display;
          sw8            <= 1'b0;
          sws            <= '0;
          host.out_valid <= 1'b1;
          state          <= S_OUT;
        end
        S_OUT: if (host.out_ready) begin
          host.out_valid <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.in_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_host_driver.sv
// Bench for cpu_host_driver: behavioural picoMIPS core model (x2=X+1, y2=Y-1)
// behind two driver instances (default timing, and SETTLE=RUN=1).
module tb_cpu_host_driver;
  import cpu_host_pkg::*;

  localparam int N  = 8;
  localparam int S0 = 4;
  localparam int R0 = 32;
  localparam int LAT0 = 4 * S0 + R0 + 5;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] ex;
    logic [N-1:0] ey;
  } vec_t;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_host_driver_if #(.n(N)) h0 ();
  cpu_host_driver_if #(.n(N)) h1 ();

  logic [N-1:0] sws0, disp0, sws1, disp1;
  logic         sw80, busy0, sw81, busy1;

  cpu_host_driver #(.n(N), .SETTLE(S0), .RUN(R0)) u_dut0 (
    .clk(clk), .reset(rst_n), .host(h0), .sws(sws0), .sw8(sw80),
    .display(disp0), .busy(busy0)
  );

  cpu_host_driver #(.n(N), .SETTLE(1), .RUN(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .host(h1), .sws(sws1), .sw8(sw81),
    .display(disp1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core model: X latched on sw8 rising, Y on sw8 falling, registered display mux.
  logic [N-1:0] cm0_x, cm0_y, cm1_x, cm1_y;
  logic [1:0]   cm0_ph, cm1_ph;
  logic         cm0_d, cm1_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm0_x <= '0; cm0_y <= '0; cm0_ph <= 2'd0; cm0_d <= 1'b0; disp0 <= '0;
    end else begin
      cm0_d <= sw80;
      disp0 <= sw80 ? cm0_y - 8'd1 : cm0_x + 8'd1;
      if (!busy0) cm0_ph <= 2'd0;
      else if (cm0_ph == 2'd0 && sw80 && !cm0_d) begin cm0_x <= sws0; cm0_ph <= 2'd1; end
      else if (cm0_ph == 2'd1 && !sw80 && cm0_d) begin cm0_y <= sws0; cm0_ph <= 2'd2; end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm1_x <= '0; cm1_y <= '0; cm1_ph <= 2'd0; cm1_d <= 1'b0; disp1 <= '0;
    end else begin
      cm1_d <= sw81;
      disp1 <= sw81 ? cm1_y - 8'd1 : cm1_x + 8'd1;
      if (!busy1) cm1_ph <= 2'd0;
      else if (cm1_ph == 2'd0 && sw81 && !cm1_d) begin cm1_x <= sws1; cm1_ph <= 2'd1; end
      else if (cm1_ph == 2'd1 && !sw81 && cm1_d) begin cm1_y <= sws1; cm1_ph <= 2'd2; end
    end
  end

  // Expected {sw8, sws} in cycle k after the accept edge (default timing).
  function automatic logic [N:0] seq_exp(input int k, input logic [N-1:0] x, input logic [N-1:0] y);
    if (k <= S0)              return {1'b0, x};
    if (k <= 2 * S0)          return {1'b1, x};
    if (k <= 3 * S0)          return {1'b1, y};
    if (k <= 4 * S0 + R0 + 2) return {1'b0, y};
    if (k <= 4 * S0 + R0 + 4) return {1'b1, y};
    return {1'b0, {N{1'b0}}};
  endfunction

  // Scoreboard and monitor for instance 0.
  res_t         sb[$];
  res_t         got;
  int           out_times[$];
  int           acc_cyc = 0;
  int           k;
  bit           lat_armed = 0;
  bit           seq_on = 0;
  bit           seq_act = 0;
  logic [N-1:0] acc_x, acc_y;
  logic [N:0]   e;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", 32'(h0.in_ready), 32'(!busy0));
      if (seq_act) begin
        k = cyc - acc_cyc + 1;
        if (k >= 1 && k <= LAT0) begin
          e = seq_exp(k, acc_x, acc_y);
          chk($sformatf("seq_sw8_c%0d", k), 32'(sw80), 32'(e[N]));
          chk($sformatf("seq_sws_c%0d", k), 32'(sws0), 32'(e[N-1:0]));
        end else begin
          seq_act = 0;
        end
      end
      if (h0.out_valid && lat_armed) begin
        chk("latency", 32'(cyc - acc_cyc + 1), 32'(LAT0));
        out_times.push_back(cyc);
        lat_armed = 0;
      end
      if (h0.out_valid && h0.out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk("sb_out_x", 32'(h0.out_x), 32'(got.x));
          chk("sb_out_y", 32'(h0.out_y), 32'(got.y));
        end
      end
      if (h0.in_valid && h0.in_ready) begin
        sb.push_back('{x: h0.in_x + 8'd1, y: h0.in_y - 8'd1});
        acc_cyc   = cyc + 1;
        acc_x     = h0.in_x;
        acc_y     = h0.in_y;
        lat_armed = 1;
        seq_act   = seq_on;
      end
    end
  end

  task automatic send0(input logic [N-1:0] x, input logic [N-1:0] y);
    int t;
    t = 0;
    @(posedge clk); #1;
    h0.in_valid = 1'b1; h0.in_x = x; h0.in_y = y;
    while (!h0.in_ready && t < 300) begin @(posedge clk); #1; t++; end
    chk("send_accept", 32'(t < 300), 32'd1);
    @(posedge clk); #1;
    h0.in_valid = 1'b0; h0.in_x = ~x; h0.in_y = ~y;
  endtask

  task automatic wait_out0(output bit ok);
    int t;
    t = 0;
    ok = 0;
    while (t < 200) begin
      @(negedge clk);
      if (h0.out_valid) begin ok = 1; break; end
      t++;
    end
    chk("out_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[5];
    logic [N-1:0] bx[3];
    logic [N-1:0] by[3];
    logic [N-1:0] cx[2];
    logic [N-1:0] cy[2];
    logic [N-1:0] cex[2];
    logic [N-1:0] cey[2];
    logic [N-1:0] ox, oy;
    bit           ok;
    int           t;

    vt[0] = '{8'h05, 8'hFB, 8'h06, 8'hFA};
    vt[1] = '{8'h00, 8'h00, 8'h01, 8'hFF};
    vt[2] = '{8'h7F, 8'h80, 8'h80, 8'h7F};
    vt[3] = '{8'hFF, 8'h01, 8'h00, 8'h00};
    vt[4] = '{8'h80, 8'h7F, 8'h81, 8'h7E};
    bx[0] = 8'h00; by[0] = 8'h00;
    bx[1] = 8'h7F; by[1] = 8'h80;
    bx[2] = 8'hFF; by[2] = 8'h01;
    cx[0] = 8'h5A; cy[0] = 8'hA5; cex[0] = 8'h5B; cey[0] = 8'hA4;
    cx[1] = 8'hFF; cy[1] = 8'h00; cex[1] = 8'h00; cey[1] = 8'hFF;

    h0.in_valid = 1'b0; h0.in_x = '0; h0.in_y = '0; h0.out_ready = 1'b1;
    h1.in_valid = 1'b0; h1.in_x = '0; h1.in_y = '0; h1.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sws", 32'(sws0), 32'd0);
    chk("rst_sw8", 32'(sw80), 32'd0);
    chk("rst_out_valid", 32'(h0.out_valid), 32'd0);
    chk("rst_out_x", 32'(h0.out_x), 32'd0);
    chk("rst_out_y", 32'(h0.out_y), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_in_ready", 32'(h0.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Table-driven pairs; the first also checks the full switch sequence.
    for (int i = 0; i < 5; i++) begin
      seq_on = (i == 0);
      send0(vt[i].x, vt[i].y);
      wait_out0(ok);
      chk($sformatf("vec%0d_x", i), 32'(h0.out_x), 32'(vt[i].ex));
      chk($sformatf("vec%0d_y", i), 32'(h0.out_y), 32'(vt[i].ey));
      @(posedge clk); #1;
      seq_on = 0;
    end

    // Backpressure
    h0.out_ready = 1'b0;
    send0(8'h3C, 8'hC3);
    wait_out0(ok);
    ox = h0.out_x;
    oy = h0.out_y;
    chk("bp_x", 32'(ox), 32'h3D);
    chk("bp_y", 32'(oy), 32'hC2);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(h0.out_valid), 32'd1);
      chk("bp_x_hold", 32'(h0.out_x), 32'(ox));
      chk("bp_y_hold", 32'(h0.out_y), 32'(oy));
      chk("bp_busy", 32'(busy0), 32'd1);
    end
    @(posedge clk); #1;
    h0.out_ready = 1'b1;
    chk("bp_still_out", 32'(h0.out_valid), 32'd1);
    chk("bp_not_ready", 32'(h0.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(h0.in_ready), 32'd1);
    chk("bp_valid_clr", 32'(h0.out_valid), 32'd0);

    // in_valid while busy is ignored
    send0(8'h21, 8'h12);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_in_run", 32'(busy0), 32'd1);
    h0.in_valid = 1'b1; h0.in_x = 8'h11; h0.in_y = 8'h11;
    @(negedge clk);
    chk("busy_pulse_ready", 32'(h0.in_ready), 32'd0);
    @(posedge clk); #1;
    h0.in_valid = 1'b0;
    wait_out0(ok);
    chk("busy_x", 32'(h0.out_x), 32'h22);
    chk("busy_y", 32'(h0.out_y), 32'h11);
    @(posedge clk); #1;
    repeat (80) @(posedge clk);
    #1;
    chk("busy_no_extra", 32'(h0.out_valid), 32'd0);
    chk("busy_idle", 32'(busy0), 32'd0);

    // Reset in REL_X aborts the transaction
    send0(8'h44, 8'h55);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_sw8", 32'(sw80), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sws", 32'(sws0), 32'd0);
    chk("mid_rst_sw8", 32'(sw80), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_valid", 32'(h0.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(h0.in_ready), 32'd1);
    sb.delete();
    lat_armed = 0;
    seq_act = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst_out_x", 32'(h0.out_x), 32'd0);
    send0(8'h66, 8'h77);
    wait_out0(ok);
    chk("post_rst_x", 32'(h0.out_x), 32'h67);
    chk("post_rst_y", 32'(h0.out_y), 32'h76);
    @(posedge clk); #1;

    // Back-to-back with in_valid and out_ready held high
    out_times.delete();
    h0.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      h0.in_valid = 1'b1; h0.in_x = bx[p]; h0.in_y = by[p];
      t = 0;
      while (!h0.in_ready && t < 300) begin @(posedge clk); #1; t++; end
      chk("b2b_accept", 32'(t < 300), 32'd1);
      @(posedge clk); #1;
    end
    h0.in_valid = 1'b0;
    wait_out0(ok);
    @(posedge clk); #1;
    chk("b2b_count", 32'(out_times.size()), 32'd3);
    if (out_times.size() == 3) begin
      for (int q = 1; q < 3; q++)
        chk($sformatf("b2b_period%0d", q), 32'(out_times[q] - out_times[q-1]), 32'd54);
    end
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // SETTLE=1, RUN=1 instance
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      h1.in_valid = 1'b1; h1.in_x = cx[p]; h1.in_y = cy[p];
      @(posedge clk); #1;
      h1.in_valid = 1'b0;
      chk("corner_busy", 32'(busy1), 32'd1);
      t = 1;
      ok = 0;
      while (t < 50) begin
        @(negedge clk);
        if (h1.out_valid) begin ok = 1; break; end
        t++;
      end
      chk("corner_timeout", 32'(ok), 32'd1);
      chk("corner_latency", 32'(t), 32'd10);
      chk("corner_x", 32'(h1.out_x), 32'(cex[p]));
      chk("corner_y", 32'(h1.out_y), 32'(cey[p]));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
